b2r_converter: RTL
==================

Name: b2r_converter

Overview:
- Block-to-row converter for the self-attention head. It accepts BLOCK_SIZE x BLOCK_SIZE result tiles from the upstream systolic matmul one strip at a time and re-emits them as row-major row segments for the downstream row consumer.
- When the whole slice (ROW_BLOCKS strips) has drained, it pulses slice_done. The self-attention controller registers that pulse and uses it to reset this block for the next slice.

Parameters:
- WIDTH, 16, bits per matrix element.
- BLOCK_SIZE, 2, tile edge length in elements.
- ROW_BLOCKS, 4, number of tile strips per slice (matrix rows = ROW_BLOCKS*BLOCK_SIZE).
- COL_BLOCKS, 4, number of tiles per strip (matrix cols = COL_BLOCKS*BLOCK_SIZE).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  tile present on in_data.
- in_ready  output  1  block accepts a tile this cycle.
- in_data  input  BLOCK_SIZE*BLOCK_SIZE*WIDTH  tile; element (i,j) at [(i*BLOCK_SIZE+j)*WIDTH +: WIDTH].
- out_valid  output  1  row segment present on out_data.
- out_ready  input  1  downstream accepts the segment.
- out_data  output  BLOCK_SIZE*WIDTH  segment; element j at [j*WIDTH +: WIDTH].
- out_row_last  output  1  high with the final segment of each matrix row.
- slice_done  output  1  one-cycle pulse after the final segment of the slice is accepted.

Behaviour:
- Reset values (rst=1 at a clock edge): state=FILL; tile, strip, row and segment counters = 0; in_ready=1; out_valid=0; out_row_last=0; slice_done=0. The strip buffer contents are don't-care.
- Reset mid-operation discards all partial strip data and counters. It takes effect at the same edge, with no output activity afterwards until FILL.
- Storage is a single strip buffer of COL_BLOCKS tiles, with no double buffering.

States:
- FILL:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready, the tile is written to buffer[tile_cnt] and tile_cnt increments.
  - Accepting tile COL_BLOCKS-1 moves the block to DRAIN on the next cycle and clears tile_cnt.
- DRAIN:
  - in_ready=0, out_valid=1.
  - out_data = row r of buffer[c], where r=row_cnt in 0..BLOCK_SIZE-1 and c=seg_cnt in 0..COL_BLOCKS-1.
  - out_row_last = (c==COL_BLOCKS-1).
  - On out_valid&&out_ready: c increments; at c wrap, c=0 and r increments.
  - If out_valid && !out_ready, out_data and out_row_last hold stable.
  - When the segment r=BLOCK_SIZE-1, c=COL_BLOCKS-1 is accepted:
    - If strip_cnt<ROW_BLOCKS-1: strip_cnt increments and the block returns to FILL.
    - Otherwise: the block goes to DONE.
- DONE:
  - slice_done=1 for exactly the first cycle in DONE, then 0.
  - in_ready=0, out_valid=0.
  - The block stays in DONE until rst. It ignores in_valid and out_ready.

Timing:
- Latency: the first segment of a strip is valid 1 cycle after the last tile of that strip is accepted.
- One segment per cycle when out_ready is held high, so a full strip drains in BLOCK_SIZE*COL_BLOCKS cycles.
- Returning to FILL has in_ready=1 the cycle after the last segment handshake.

Boundaries:
- in_valid while in DRAIN or DONE: the tile is not accepted and the sender must hold it.
- rst asserted in the same cycle as a handshake: rst wins and the handshake is void.
- With BLOCK_SIZE=1 or COL_BLOCKS=1 the counters degenerate correctly. out_row_last is then high on every segment when COL_BLOCKS=1.
- Counter widths: $clog2 of (count+1).

Test Plan:
- Reset and idle: hold rst 3 cycles then release, with no traffic. Required: in_ready=1, out_valid=0, slice_done=0, out_row_last=0 throughout.
- Single strip, defaults: send tiles whose element (i,j) of tile t = 16'h0100*t + 16*i + j, one per cycle, with out_ready=1.
  - 8 segments follow, starting 1 cycle after tile 3.
  - Segment order for (r,c): (0,0)=[0000,0001], (0,1)=[0100,0101] … (1,3)=[0310,0311].
  - out_row_last is high on segments 3 and 7.
  - in_ready returns to 1 after segment 7.
- Full slice: 16 tiles and 32 segments, out_ready=1. Required: slice_done pulses exactly once, one cycle after the 32nd handshake. After that, out_valid=0 and in_ready=0 permanently until rst.
- Backpressure: toggle out_ready 1/0 every cycle during DRAIN. Required: out_data is stable while stalled, no segment is lost or duplicated, and 8 handshakes complete in 15 cycles.
- Input stall and illegal push: gap in_valid (1,0,0,1,1,0,1) during FILL, and drive in_valid=1 throughout DRAIN. Required: exactly 4 tiles are captured per strip and DRAIN data is unaffected.
- Reset mid-DRAIN: assert rst after segment 3 of strip 2. Required: the next cycle is FILL with all counters 0. A subsequent full 16-tile slice reproduces the golden 32-segment sequence and a single slice_done.

Source files
------------

// File: rtl/b2r_converter.sv
// Block-to-row converter: gathers one strip of BLOCK_SIZE x BLOCK_SIZE tiles
// into a single strip buffer, then replays it as row-major row segments.
// After ROW_BLOCKS strips it parks in DONE and pulses slice_done once.
module b2r_converter #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned BLOCK_SIZE = 2,
  parameter int unsigned ROW_BLOCKS = 4,
  parameter int unsigned COL_BLOCKS = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [BLOCK_SIZE*BLOCK_SIZE*WIDTH-1:0] in_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [BLOCK_SIZE*WIDTH-1:0]           out_data,
  output logic                                  out_row_last,
  output logic                                  slice_done
);

  localparam int unsigned TILE_W = BLOCK_SIZE * BLOCK_SIZE * WIDTH;
  localparam int unsigned SEG_W  = BLOCK_SIZE * WIDTH;
  localparam int unsigned TCNT_W = $clog2(COL_BLOCKS + 1);
  localparam int unsigned RCNT_W = $clog2(BLOCK_SIZE + 1);
  localparam int unsigned SCNT_W = $clog2(ROW_BLOCKS + 1);
  localparam int unsigned IDX_W  = (COL_BLOCKS > 1) ? $clog2(COL_BLOCKS) : 1;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state_q;
  logic [TCNT_W-1:0]   tile_q;
  logic [TCNT_W-1:0]   seg_q;
  logic [RCNT_W-1:0]   row_q;
  logic [SCNT_W-1:0]   strip_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                out_row_last_q;
  logic                slice_done_q;
  logic [SEG_W-1:0]    out_data_q;

  logic [TILE_W-1:0]   buf_q [COL_BLOCKS];

  logic                seg_wrap_d;
  logic                row_wrap_d;
  logic [TCNT_W-1:0]   seg_d;
  logic [RCNT_W-1:0]   row_d;
  logic [TILE_W-1:0]   fill_tile0_d;
  logic [SEG_W-1:0]    next_seg_data_d;

  // Extract row r of a tile as one output segment.
  function automatic logic [SEG_W-1:0] row_of(input logic [TILE_W-1:0] t,
                                               input logic [RCNT_W-1:0] r);
    return t[int'(r)*SEG_W +: SEG_W];
  endfunction

  // Next drain coordinates and the segment they select, used on each handshake.
  always_comb begin
    seg_wrap_d      = (seg_q == TCNT_W'(COL_BLOCKS - 1));
    row_wrap_d      = (row_q == RCNT_W'(BLOCK_SIZE - 1));
    seg_d           = seg_wrap_d ? '0 : seg_q + TCNT_W'(1);
    row_d           = row_q;
    if (seg_wrap_d) begin
      row_d = row_wrap_d ? '0 : row_q + RCNT_W'(1);
    end
    // With a single-tile strip the first segment comes from the tile arriving now.
    fill_tile0_d    = (COL_BLOCKS == 1) ? in_data : buf_q[0];
    next_seg_data_d = row_of(buf_q[seg_d[IDX_W-1:0]], row_d);
  end

  // Strip buffer write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (!rst && state_q == FILL && in_valid) begin
      buf_q[tile_q[IDX_W-1:0]] <= in_data;
    end
  end

  // Control FSM with registered handshake and data outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= FILL;
      tile_q         <= '0;
      seg_q          <= '0;
      row_q          <= '0;
      strip_q        <= '0;
      in_ready_q     <= 1'b1;
      out_valid_q    <= 1'b0;
      out_row_last_q <= 1'b0;
      slice_done_q   <= 1'b0;
      out_data_q     <= '0;
    end else begin
      case (state_q)
        FILL: begin
          if (in_valid) begin
            if (tile_q == TCNT_W'(COL_BLOCKS - 1)) begin
              tile_q         <= '0;
              state_q        <= DRAIN;
              in_ready_q     <= 1'b0;
              out_valid_q    <= 1'b1;
              out_row_last_q <= (COL_BLOCKS == 1);
              out_data_q     <= row_of(fill_tile0_d, '0);
            end else begin
              tile_q <= tile_q + TCNT_W'(1);
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            seg_q          <= seg_d;
            row_q          <= row_d;
            out_data_q     <= next_seg_data_d;
            out_row_last_q <= (seg_d == TCNT_W'(COL_BLOCKS - 1));
            if (seg_wrap_d && row_wrap_d) begin
              out_valid_q    <= 1'b0;
              out_row_last_q <= 1'b0;
              if (strip_q == SCNT_W'(ROW_BLOCKS - 1)) begin
                state_q      <= DONE;
                slice_done_q <= 1'b1;
              end else begin
                strip_q    <= strip_q + SCNT_W'(1);
                state_q    <= FILL;
                in_ready_q <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          slice_done_q <= 1'b0;
        end
        default: begin
          state_q <= FILL;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_row_last = out_row_last_q;
  assign slice_done   = slice_done_q;

endmodule
